// File: rtl/ringosc_pkg.sv
// rtl/ringosc_pkg.sv - shared types and constants for the ring-oscillator frequency meter
package ringosc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meter_state_t;

    localparam int ARM_CYCLES  = 3;
    localparam int SYNC_STAGES = 2;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ringosc_freq_meter_sync.sv
// rtl/ringosc_freq_meter_sync.sv - oscillator synchroniser with rising-edge detect
module osc_edge_sync
    import ringosc_pkg::*;
(
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ringosc_freq_meter.sv
// rtl/ringosc_freq_meter.sv - gated edge counter measuring one selected ring oscillator
module ringosc_freq_meter
    import ringosc_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    parameter  int GATE_W = 16,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] osc_in,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam int PAD_W = 2 ** SEL_W;
    localparam logic [1:0] ARM_LAST = 2'(ARM_CYCLES - 1);

    meter_state_t      r_state;
    logic [SEL_W-1:0]  r_ch_sel;
    logic [GATE_W-1:0] r_gate_left;
    logic [1:0]        r_arm_cnt;
    logic [CNT_W-1:0]  r_run_cnt;
    logic              r_ovf_run;

    logic [PAD_W-1:0]  w_osc_pad;
    logic              w_osc_sel;
    logic              w_edge;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_ovf_next;

    // Unused select codes read zero-padded lanes, so an out-of-range channel counts nothing.
    always_comb begin
        w_osc_pad               = '0;
        w_osc_pad[NUM_CH-1:0]   = osc_in;
    end
    assign w_osc_sel = w_osc_pad[r_ch_sel];

    osc_edge_sync u_sync (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_async (w_osc_sel),
        .o_edge  (w_edge)
    );

    always_comb begin
        w_cnt_next = r_run_cnt;
        w_ovf_next = r_ovf_run;
        if (r_state == ST_GATE && w_edge) begin
            if (&r_run_cnt) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_run_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ch_sel    <= '0;
            r_gate_left <= '0;
            r_arm_cnt   <= '0;
            r_run_cnt   <= '0;
            r_ovf_run   <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        r_ch_sel    <= ch_sel;
                        r_gate_left <= gate_cycles;
                        r_arm_cnt   <= '0;
                        r_run_cnt   <= '0;
                        r_ovf_run   <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                    if (r_arm_cnt == ARM_LAST) begin
                        if (r_gate_left == '0) begin
                            count    <= r_run_cnt;
                            overflow <= r_ovf_run;
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_GATE;
                        end
                    end
                end
                ST_GATE: begin
                    r_run_cnt   <= w_cnt_next;
                    r_ovf_run   <= w_ovf_next;
                    r_gate_left <= r_gate_left - 1'b1;
                    // The final gate cycle's edge must land in the published result.
                    if (r_gate_left == GATE_W'(1)) begin
                        count    <= w_cnt_next;
                        overflow <= w_ovf_next;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
Parametrised on-chip frequency meter for a bank of ring oscillators. It replaces the single free-running oscillator driven straight to a pin.
- Selects one of NUM_CH oscillator outputs.
- Synchronises it into clk.
- Counts its rising edges over a programmable gate window of clk cycles.
- Reports a saturating count with valid/overflow flags, so that tt_um_* top logic can drive the result onto uo_out/uio_out.

Parameters:
NUM_CH, 4, number of ring-oscillator inputs (1..16)
CNT_W, 16, width of edge counter and result
GATE_W, 16, width of gate-length value in clk cycles
SEL_W, $clog2(NUM_CH) (min 1), width of channel select (derived, not overridden)

Ports:
clk  in  1  system clock, the codebase's clk
rst_n  in  1  reset, synchronous active-low, the codebase's rst_n
osc_in  in  NUM_CH  asynchronous ring-oscillator outputs
ch_sel  in  SEL_W  channel to measure, sampled on accepted start
gate_cycles  in  GATE_W  gate window length, sampled on accepted start
start  in  1  single-cycle request; level also accepted
busy  out  1  high from cycle after accepted start until result cycle
valid  out  1  one-cycle pulse when count is updated
overflow  out  1  result saturated; held with count
count  out  CNT_W  edge count of last measurement; held until next result

Behaviour:
- Reset (rst_n low at posedge clk) clears all state. Outputs:
  - busy=0, valid=0, overflow=0, count=0.
  - FSM goes to IDLE.
  - Synchroniser flops go to 0.
- Reset mid-measurement aborts immediately and no valid pulse is produced.
- Input path:
  - Mux selects osc_in[ch_sel_q].
  - The mux output feeds a 2-flop synchroniser, then an edge-detect flop.
  - An edge is counted when sync=1 and prev=0.
  - Measurable frequency is below clk/2; faster inputs alias, which is acceptable and documented.
  - If ch_sel_q >= NUM_CH, the mux outputs constant 0 and the count is 0.
- FSM states: IDLE, ARM, GATE, DONE (one-hot or binary; encoding lives in the package).
- IDLE:
  - start=1 latches ch_sel_q and gate_q, clears the running counter, sets busy and goes to ARM.
  - If start is held high, a new measurement starts on the cycle after DONE.
- ARM: lasts exactly 3 cycles to flush the synchroniser and prime prev with the new channel. No counting; transition ignored.
- GATE:
  - gate_q == 0: ARM goes straight to DONE and the result is 0.
  - Otherwise the FSM stays in GATE exactly gate_q cycles, with the edge test evaluated in each of those cycles.
  - The running counter increments per edge and saturates at 2^CNT_W-1.
  - An increment attempted at max sets ovf_run.
- DONE (1 cycle):
  - count <= running counter, overflow <= ovf_run, valid=1 this cycle, busy=0.
  - Next state is IDLE.
- Latency: start accepted at cycle T → valid at T+4+gate_q (T+4 when gate_q=0).
- start while busy is ignored and has no effect on the latched ch_sel or gate.
- ch_sel and gate_cycles changing during a measurement have no effect.
- count/overflow change only in DONE or on reset.

Decomposition:
- Package ringosc_pkg:
  - FSM state typedef/localparams.
  - ARM_CYCLES=3.
  - SYNC_STAGES=2.
- Sub-module osc_edge_sync: SYNC_STAGES synchroniser plus edge-detect flop. It has a synchronous active-low clear and outputs a one-cycle edge pulse.
- Mux, FSM and counter stay in ringosc_freq_meter (≈150–250 lines).

Test Plan:
- osc_in[1] square wave period 4 clk, ch_sel=1, gate_cycles=100, start → valid at T+104, count=25, overflow=0.
- CNT_W=4 build, osc period 2 clk, gate_cycles=64 → count=15, overflow=1; next run with gate_cycles=10 → count=5, overflow=0.
- gate_cycles=0, start → valid at T+4, count=0, busy high for exactly cycles T+1..T+3.
- start pulsed again at T+10 during a 100-cycle gate with ch_sel changed to 2 → ignored; result is from channel 1; busy is continuous.
- rst_n low at T+50 mid-GATE → next cycle busy=0, count=0, no valid pulse; a fresh start then measures correctly.
- NUM_CH=3 build, ch_sel=3 with all osc toggling → count=0; ch_sel=0 at period 8 clk with gate 80 → count=10 ±1 depending on phase.
